dma_burst_controller: RTL and testbench
=======================================

Name: dma_burst_controller

Overview:
- DMA engine that consumes the DMA command word published by the bus arbiter/handler.
- Sequence per command: request the memory bus, copy a block of words from an external device FIFO into memory, release the bus, pulse a completion signal back to the handler/CPU.
- Yields the bus for one cycle between bursts so pending CPU memory operations can proceed.

Parameters:
- WORD_SIZE, 16, data/address width; command width is 2*WORD_SIZE+1.
- BURST_LEN, 4, words written per bus tenure before the request is dropped for one cycle.
- MEM_LATENCY, 2, cycles each memory write is held on the bus (minimum 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous and active-high: reset_n=1 at a rising edge resets the block.
- dma_command  in  2*WORD_SIZE+1  {valid, start_address, length}; valid is the MSB.
- bus_request  out  1  memory bus request to the handler.
- bus_grant  in  1  memory bus grant from the handler.
- mem_writeM  out  1  memory write strobe; high-Z when bus_grant=0.
- mem_address  out  WORD_SIZE  memory address; high-Z when bus_grant=0.
- mem_data  out  WORD_SIZE  memory write data; high-Z when bus_grant=0.
- dev_data  in  WORD_SIZE  device FIFO head word.
- dev_valid  in  1  device FIFO non-empty.
- dev_ready  out  1  one-cycle pop of the device FIFO head.
- dma_end  out  1  one-cycle completion pulse (interrupt source).
- dma_busy  out  1  high from command accept until dma_end.

Behaviour:
- Reset values:
  - bus_request=0, dev_ready=0, dma_end=0, dma_busy=0.
  - Counters cleared, FSM=IDLE, mem_writeM=0 internally; tri-state rules still apply.
  - Reset mid-transfer discards the in-flight word and the command; no dma_end.
- States: IDLE, REQ, WAIT_DATA, WRITE, YIELD, DONE.
- IDLE:
  - Latch start_address and length when valid=1. Valid is level-sampled; only accepted in IDLE.
  - Valid held high after completion does not retrigger until it has been seen low for at least one cycle.
  - length=0 -> DONE directly; bus_request is never asserted.
  - Otherwise -> REQ; dma_busy=1.
- REQ: bus_request=1. The cycle bus_grant=1 is sampled -> WAIT_DATA.
- WAIT_DATA: bus_request held. dev_valid=1 -> WRITE; the word is captured from dev_data.
- WRITE:
  - mem_writeM=1; mem_address=start_address+word_count (WORD_SIZE wrap, modulo 2^WORD_SIZE); mem_data=captured word.
  - Held stable for exactly MEM_LATENCY cycles.
  - dev_ready=1 on the last WRITE cycle only.
  - word_count and burst_count increment at the end of WRITE.
- After WRITE:
  - word_count==length -> DONE.
  - Else burst_count==BURST_LEN -> YIELD.
  - Else -> WAIT_DATA.
- YIELD: bus_request=0 for exactly one cycle; burst_count cleared -> REQ.
- DONE: bus_request=0, dma_end=1 for one cycle, dma_busy=0 next cycle -> IDLE.
- Grant loss while bus_request=1 (WAIT_DATA/WRITE):
  - Current word aborted: dev_ready not pulsed, counts unchanged.
  - -> REQ; the word is rewritten after re-grant.
- mem_* outputs drive only while bus_grant=1; otherwise high-Z, so the handler's CPU path owns the bus.
- Between DONE and the next accept, dma_command changes are ignored.
- Counters are WORD_SIZE bits wide; the maximum length is 2^WORD_SIZE-1.

Test Plan:
- Basic transfer:
  - Stimulus: BURST_LEN=4, MEM_LATENCY=2, command {1,0x01f4,12}, grant 1 cycle after request, dev_valid always 1.
  - Response: 12 writes to 0x01f4..0x01ff carrying FIFO words in order; exactly 12 dev_ready pulses; bus_request low exactly 2 single cycles (after words 4 and 8); one dma_end pulse; dma_busy low after.
- Zero length:
  - Stimulus: command {1,0x0100,0}.
  - Response: bus_request never high; dma_end pulses 2 cycles after accept; no writes.
- FIFO starvation:
  - Stimulus: dev_valid low for 5 cycles before word 3.
  - Response: bus_request stays high, mem_writeM=0 during the stall, address 0x01f6 written once after dev_valid rises.
- Delayed grant:
  - Stimulus: bus_grant withheld 6 cycles (CPU busy).
  - Response: no mem_* activity; mem_* high-Z until grant; first write at 0x01f4 on the grant cycle +1.
- Grant drop mid-WRITE:
  - Stimulus: grant drop on word 5.
  - Response: no dev_ready for that attempt; word 5 rewritten to 0x01f8 after re-grant; total dev_ready count 12.
- Reset mid-transfer:
  - Stimulus: reset_n=1 during word 7, then a new command {1,0x0200,3}.
  - Response: all outputs at reset values; no dma_end for the first command; new transfer writes 0x0200..0x0202 then dma_end.

Source files
------------

// File: rtl/dma_burst_controller.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_controller
// Brief    : Copies a block of device-FIFO words into memory in bus bursts,
//            yielding the bus for one cycle between bursts.
// Revision : 1.0
// ============================================================================
module dma_burst_controller #(
    parameter int WORD_SIZE   = 16,
    parameter int BURST_LEN   = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2*WORD_SIZE:0]   dma_command,
    output logic                   bus_request,
    input  logic                   bus_grant,
    output wire                    mem_writeM,
    output wire  [WORD_SIZE-1:0]   mem_address,
    output wire  [WORD_SIZE-1:0]   mem_data,
    input  logic [WORD_SIZE-1:0]   dev_data,
    input  logic                   dev_valid,
    output logic                   dev_ready,
    output logic                   dma_end,
    output logic                   dma_busy
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0]     c_LAT_LAST = LAT_W'(MEM_LATENCY - 1);
    localparam logic [WORD_SIZE-1:0] c_ONE      = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] c_BURST    = WORD_SIZE'(BURST_LEN);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_REQ   = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_YIELD = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] len_q, len_d;
    logic [WORD_SIZE-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_SIZE-1:0] burst_cnt_q, burst_cnt_d;
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 armed_q, armed_d;

    logic                 w_cmd_valid;
    logic [WORD_SIZE-1:0] w_cmd_addr;
    logic [WORD_SIZE-1:0] w_cmd_len;
    logic                 w_write;
    logic                 w_last_beat;
    logic [WORD_SIZE-1:0] w_word_inc;
    logic [WORD_SIZE-1:0] w_burst_inc;
    logic [WORD_SIZE-1:0] w_mem_addr;

    assign w_cmd_valid = dma_command[2*WORD_SIZE];
    assign w_cmd_addr  = dma_command[2*WORD_SIZE-1:WORD_SIZE];
    assign w_cmd_len   = dma_command[WORD_SIZE-1:0];
    assign w_write     = (state_q == c_ST_WRITE);
    assign w_last_beat = w_write && (lat_cnt_q == c_LAT_LAST);
    assign w_word_inc  = word_cnt_q + c_ONE;
    assign w_burst_inc = burst_cnt_q + c_ONE;
    assign w_mem_addr  = addr_q + word_cnt_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        burst_cnt_d = burst_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        data_d      = data_q;
        // A held-high valid must be seen low once before it can start another command
        armed_d     = armed_q | ~w_cmd_valid;
        case (state_q)
            c_ST_IDLE: begin
                if (w_cmd_valid && armed_q) begin
                    addr_d      = w_cmd_addr;
                    len_d       = w_cmd_len;
                    word_cnt_d  = '0;
                    burst_cnt_d = '0;
                    armed_d     = 1'b0;
                    state_d     = (w_cmd_len == '0) ? c_ST_DONE : c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (bus_grant) begin
                    state_d = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (!bus_grant) begin
                    state_d = c_ST_REQ;
                end else if (dev_valid) begin
                    data_d    = dev_data;
                    lat_cnt_d = '0;
                    state_d   = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                // Losing the grant drops the word; it is re-fetched from the FIFO head later
                if (!bus_grant) begin
                    state_d = c_ST_REQ;
                end else if (lat_cnt_q == c_LAT_LAST) begin
                    word_cnt_d  = w_word_inc;
                    burst_cnt_d = w_burst_inc;
                    if (w_word_inc == len_q) begin
                        state_d = c_ST_DONE;
                    end else if (w_burst_inc == c_BURST) begin
                        state_d = c_ST_YIELD;
                    end else begin
                        state_d = c_ST_WAIT;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            c_ST_YIELD: begin
                burst_cnt_d = '0;
                state_d     = c_ST_REQ;
            end
            c_ST_DONE: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q     <= c_ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
            lat_cnt_q   <= '0;
            data_q      <= '0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            data_q      <= data_d;
            armed_q     <= armed_d;
        end
    end

    assign bus_request = (state_q == c_ST_REQ) || (state_q == c_ST_WAIT) || w_write;
    assign dev_ready   = w_last_beat && bus_grant;
    assign dma_end     = (state_q == c_ST_DONE);
    assign dma_busy    = (state_q != c_ST_IDLE);

    // The CPU path owns the memory bus whenever the grant is withdrawn
    assign mem_writeM  = bus_grant ? w_write    : 1'bz;
    assign mem_address = bus_grant ? w_mem_addr : {WORD_SIZE{1'bz}};
    assign mem_data    = bus_grant ? data_q     : {WORD_SIZE{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_burst_controller
// Brief    : Randomized self-checking bench with a handler/FIFO responder and a
//            transaction-level model of the expected memory writes.
// Revision : 1.0
// ============================================================================
module tb_dma_burst_controller;

    localparam int W  = 16;
    localparam int BL = 4;
    localparam int ML = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [2*W:0]   dma_command;
    logic           bus_request;
    logic           bus_grant;
    wire            mem_writeM;
    wire  [W-1:0]   mem_address;
    wire  [W-1:0]   mem_data;
    logic [W-1:0]   dev_data;
    logic           dev_valid;
    logic           dev_ready;
    logic           dma_end;
    logic           dma_busy;

    always #5 clk = ~clk;

    dma_burst_controller #(.WORD_SIZE(W), .BURST_LEN(BL), .MEM_LATENCY(ML)) dut (
        .clk(clk), .reset_n(reset_n), .dma_command(dma_command),
        .bus_request(bus_request), .bus_grant(bus_grant),
        .mem_writeM(mem_writeM), .mem_address(mem_address), .mem_data(mem_data),
        .dev_data(dev_data), .dev_valid(dev_valid), .dev_ready(dev_ready),
        .dma_end(dma_end), .dma_busy(dma_busy)
    );

    int checks = 0;
    int passes = 0;

    // Run configuration, written only by the stimulus process
    int         run_id = 0;
    logic [W-1:0] fifo [0:63];
    int         fifo_n = 0;
    logic [W-1:0] cfg_start = '0;
    int         cfg_withhold = 0;
    int         cfg_drop = -1;
    int         cfg_stall_idx = -1;
    int         cfg_stall_n = 0;
    int         cfg_rst_at = -1;

    // Observations, written only by the responder process
    int         cyc = 0;
    int         seen_run = -1;
    int         commits, wm_cyc, hold_err, nogrant_wr, req_hi, req_low, ends;
    int         first_req, first_gnt, first_wr, first_end, busy_rises;
    int         wh_left, drop_at, drop_left, drop_done, stall_left, stall_req_low;
    int         rst_at, rst_phase, rst_hold;
    bit         seen_req, busy_prev, req_prev;
    logic [4:0] rst_snap;
    logic [W-1:0] wr_addr [$];
    logic [W-1:0] wr_data [$];

    // Handler + device FIFO responder: samples the DUT, then drives grant/FIFO/reset
    initial begin : responder
        logic [W-1:0] ea;
        bit wrote;
        reset_n   = 1'b1;
        rst_hold  = 3;
        bus_grant = 1'b0;
        dev_valid = 1'b0;
        dev_data  = '0;
        req_prev  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (run_id != seen_run) begin
                seen_run = run_id;
                commits = 0; wm_cyc = 0; hold_err = 0; nogrant_wr = 0;
                req_hi = 0; req_low = 0; ends = 0; busy_rises = 0;
                first_req = -1; first_gnt = -1; first_wr = -1; first_end = -1;
                seen_req = 1'b0; busy_prev = dma_busy;
                wr_addr.delete(); wr_data.delete();
                wh_left = cfg_withhold; drop_at = cfg_drop; drop_left = 0; drop_done = 0;
                stall_left = cfg_stall_n; stall_req_low = 0;
                rst_at = cfg_rst_at; rst_phase = 0; rst_snap = '1;
            end
            wrote = bus_grant && (mem_writeM === 1'b1);
            if (rst_phase == 1) begin
                rst_snap  = {bus_request, dev_ready, dma_end, dma_busy, mem_writeM === 1'b1};
                rst_phase = 2;
            end
            if (wrote) begin
                wm_cyc++;
                if (first_wr < 0) first_wr = cyc;
                ea = cfg_start + W'(commits);
                if (mem_address !== ea || mem_data !== fifo[commits]) hold_err++;
            end else if (mem_writeM === 1'b1) begin
                nogrant_wr++;
            end
            if (bus_request === 1'b1) begin
                req_hi++;
                seen_req = 1'b1;
                if (first_req < 0) first_req = cyc;
            end else if (dma_busy && seen_req && !dma_end) begin
                req_low++;
            end
            if (dma_busy && !busy_prev) busy_rises++;
            busy_prev = dma_busy;
            if (dma_end === 1'b1) begin
                ends++;
                if (first_end < 0) first_end = cyc;
            end
            if (bus_grant && first_gnt < 0) first_gnt = cyc;
            if (dev_ready === 1'b1) begin
                wr_addr.push_back(mem_address);
                wr_data.push_back(mem_data);
                commits++;
            end
            if (wrote && drop_at >= 0 && mem_address == W'(drop_at)) begin
                drop_left = 2; drop_at = -1; drop_done++;
            end
            if (wrote && rst_at >= 0 && mem_address == W'(rst_at)) begin
                rst_hold = 1; rst_phase = 1; rst_at = -1;
            end
            reset_n = (rst_hold > 0);
            if (rst_hold > 0) rst_hold--;
            // Grant follows request by one cycle unless withheld or forcibly dropped
            if (drop_left > 0) begin
                bus_grant = 1'b0;
                drop_left--;
            end else if (bus_request && wh_left > 0) begin
                bus_grant = 1'b0;
                wh_left--;
            end else begin
                bus_grant = bus_request && req_prev;
            end
            req_prev = bus_request;
            if (commits == cfg_stall_idx && stall_left > 0) begin
                dev_valid = 1'b0;
                stall_left--;
                if (!bus_request) stall_req_low++;
            end else begin
                dev_valid = (commits < fifo_n);
            end
            dev_data = fifo[(commits < 64) ? commits : 63];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic new_run(input logic [W-1:0] start, input int n);
        for (int i = 0; i < 64; i++) fifo[i] = W'($urandom);
        fifo_n        = n;
        cfg_start     = start;
        cfg_withhold  = 0;
        cfg_drop      = -1;
        cfg_stall_idx = -1;
        cfg_stall_n   = 0;
        cfg_rst_at    = -1;
        run_id++;
    endtask

    task automatic run_cmd(input logic [W-1:0] start, input logic [W-1:0] len,
                           input bit hold_valid, output int issue_cyc);
        bit done;
        done        = 1'b0;
        issue_cyc   = cyc;
        dma_command = {1'b1, start, len};
        for (int i = 0; i < 800 && !done; i++) begin
            tick;
            if (!hold_valid && (dma_busy || ends > 0)) dma_command[2*W] = 1'b0;
            if (ends > 0 || rst_phase == 2) done = 1'b1;
        end
        if (!hold_valid) dma_command = '0;
        if (!done) begin
            checks++;
            $display("FAIL timeout: no dma_end for cmd addr=%h len=%0d", start, len);
        end
        tick;
        tick;
    endtask

    task automatic test_reset;
        repeat (6) tick;
        checks++;
        if ({bus_request, dev_ready, dma_end, dma_busy} !== 4'b0000)
            $display("FAIL reset_outputs: got %b want 0000", {bus_request, dev_ready, dma_end, dma_busy});
        else passes++;
        checks++;
        if (mem_writeM === 1'b1) $display("FAIL reset_writeM: got %b want not 1", mem_writeM);
        else passes++;
    endtask

    task automatic test_basic;
        int t0;
        logic [W-1:0] ea;
        new_run(16'h01f4, 12);
        run_cmd(16'h01f4, 16'd12, 1'b0, t0);
        checks++;
        if (commits !== 12 || wr_addr.size() !== 12) $display("FAIL basic_pops: got %0d want 12", commits);
        else passes++;
        for (int i = 0; i < wr_addr.size() && i < 12; i++) begin
            ea = 16'h01f4 + W'(i);
            checks++;
            if (wr_addr[i] !== ea || wr_data[i] !== fifo[i])
                $display("FAIL basic_word%0d: got %h/%h want %h/%h", i, wr_addr[i], wr_data[i], ea, fifo[i]);
            else passes++;
        end
        checks++;
        if (req_low !== 2) $display("FAIL basic_yields: got %0d want 2", req_low);
        else passes++;
        checks++;
        if (ends !== 1 || dma_busy !== 1'b0) $display("FAIL basic_end: ends=%0d busy=%b want 1/0", ends, dma_busy);
        else passes++;
        checks++;
        if (wm_cyc !== 12*ML || hold_err !== 0 || nogrant_wr !== 0)
            $display("FAIL basic_hold: cycles=%0d err=%0d nogrant=%0d want %0d/0/0", wm_cyc, hold_err, nogrant_wr, 12*ML);
        else passes++;
    endtask

    task automatic test_zero_len;
        int t0;
        new_run(16'h0100, 0);
        run_cmd(16'h0100, 16'd0, 1'b0, t0);
        checks++;
        if (req_hi !== 0 || commits !== 0 || wm_cyc !== 0)
            $display("FAIL zero_activity: req=%0d pops=%0d writes=%0d want 0", req_hi, commits, wm_cyc);
        else passes++;
        checks++;
        if (ends !== 1 || first_end - t0 !== 2)
            $display("FAIL zero_end: ends=%0d delay=%0d want 1/2", ends, first_end - t0);
        else passes++;
    endtask

    task automatic test_starvation;
        int t0;
        int hits;
        new_run(16'h01f4, 12);
        cfg_stall_idx = 2;
        cfg_stall_n   = 5;
        run_cmd(16'h01f4, 16'd12, 1'b0, t0);
        hits = 0;
        for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] == 16'h01f6) hits++;
        checks++;
        if (hits !== 1 || commits !== 12) $display("FAIL starve_word: got %0d writes of 01f6, %0d pops want 1/12", hits, commits);
        else passes++;
        checks++;
        if (stall_req_low !== 0 || req_low !== 2)
            $display("FAIL starve_req: stall_low=%0d yields=%0d want 0/2", stall_req_low, req_low);
        else passes++;
        checks++;
        if (wm_cyc !== 12*ML || hold_err !== 0)
            $display("FAIL starve_hold: cycles=%0d err=%0d want %0d/0", wm_cyc, hold_err, 12*ML);
        else passes++;
    endtask

    task automatic test_delayed_grant;
        int t0;
        new_run(16'h01f4, 12);
        cfg_withhold = 6;
        run_cmd(16'h01f4, 16'd12, 1'b0, t0);
        checks++;
        if (nogrant_wr !== 0 || first_gnt - first_req < 6)
            $display("FAIL dgrant_idle: nogrant=%0d wait=%0d want 0/>=6", nogrant_wr, first_gnt - first_req);
        else passes++;
        checks++;
        if (first_wr - first_gnt !== 1 || wr_addr.size() == 0 || wr_addr[0] !== 16'h01f4)
            $display("FAIL dgrant_first: delay=%0d want 1, first addr must be 01f4", first_wr - first_gnt);
        else passes++;
    endtask

    task automatic test_grant_drop;
        int t0;
        logic [W-1:0] ea;
        int bad;
        new_run(16'h01f4, 12);
        cfg_drop = 16'h01f8;
        run_cmd(16'h01f4, 16'd12, 1'b0, t0);
        checks++;
        if (drop_done !== 1 || commits !== 12) $display("FAIL drop_pops: drops=%0d pops=%0d want 1/12", drop_done, commits);
        else passes++;
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            ea = 16'h01f4 + W'(i);
            if (wr_addr[i] !== ea || wr_data[i] !== fifo[i]) bad++;
        end
        checks++;
        if (bad !== 0 || wr_addr.size() !== 12) $display("FAIL drop_words: got %0d bad of %0d want 0 of 12", bad, wr_addr.size());
        else passes++;
        checks++;
        if (wm_cyc !== 12*ML + 1 || hold_err !== 0)
            $display("FAIL drop_cycles: got %0d err=%0d want %0d/0", wm_cyc, hold_err, 12*ML + 1);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int t0;
        new_run(16'h01f4, 12);
        cfg_rst_at = 16'h01fa;
        run_cmd(16'h01f4, 16'd12, 1'b0, t0);
        repeat (8) tick;
        checks++;
        if (rst_snap !== 5'b00000) $display("FAIL rstmid_outputs: got %b want 00000", rst_snap);
        else passes++;
        checks++;
        if (ends !== 0 || commits !== 6) $display("FAIL rstmid_abort: ends=%0d pops=%0d want 0/6", ends, commits);
        else passes++;
        new_run(16'h0200, 3);
        run_cmd(16'h0200, 16'd3, 1'b0, t0);
        checks++;
        if (wr_addr.size() !== 3 || wr_addr[0] !== 16'h0200 || wr_addr[2] !== 16'h0202
            || wr_data[0] !== fifo[0] || wr_data[2] !== fifo[2] || ends !== 1)
            $display("FAIL rstmid_new: got %0d writes, ends=%0d want 3 writes 0200..0202, 1 end", wr_addr.size(), ends);
        else passes++;
    endtask

    task automatic test_valid_hold;
        int t0;
        new_run(16'h0300, 1);
        run_cmd(16'h0300, 16'd1, 1'b1, t0);
        repeat (8) tick;
        checks++;
        if (busy_rises !== 1 || commits !== 1 || ends !== 1)
            $display("FAIL hold_retrigger: busy_rises=%0d pops=%0d ends=%0d want 1/1/1", busy_rises, commits, ends);
        else passes++;
        dma_command = '0;
        repeat (3) tick;
    endtask

    task automatic test_random;
        int t0;
        int len;
        int bad;
        logic [W-1:0] start;
        logic [W-1:0] ea;
        for (int it = 0; it < 4; it++) begin
            len   = $urandom_range(1, 20);
            start = (it == 0) ? W'(16'hfff8 + $urandom_range(0, 7)) : W'($urandom);
            new_run(start, len);
            cfg_stall_idx = $urandom_range(0, len - 1);
            cfg_stall_n   = $urandom_range(0, 4);
            cfg_withhold  = $urandom_range(0, 3);
            run_cmd(start, W'(len), 1'b0, t0);
            bad = 0;
            for (int i = 0; i < wr_addr.size(); i++) begin
                ea = start + W'(i);
                if (wr_addr[i] !== ea || wr_data[i] !== fifo[i]) bad++;
            end
            checks++;
            if (bad !== 0 || wr_addr.size() !== len || ends !== 1)
                $display("FAIL rand%0d_words: bad=%0d writes=%0d ends=%0d want 0/%0d/1", it, bad, wr_addr.size(), ends, len);
            else passes++;
            checks++;
            if (req_low !== (len - 1) / BL || wm_cyc !== ML * len || hold_err !== 0)
                $display("FAIL rand%0d_bus: yields=%0d cycles=%0d err=%0d want %0d/%0d/0",
                         it, req_low, wm_cyc, hold_err, (len - 1) / BL, ML * len);
            else passes++;
        end
    endtask

    initial begin
        dma_command = '0;
        test_reset;
        test_basic;
        test_zero_len;
        test_starvation;
        test_delayed_grant;
        test_grant_drop;
        test_reset_mid;
        test_valid_hold;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
